// File: rtl/sortmax_sched.sv
// sortmax_sched: loads an N-word block, bubble-sorts it descending with one
// shared compare-exchange unit, then streams it out with the block maximum.
module sortmax_sched #(
   parameter int N = 8,
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         out_last,
   output logic         max_valid,
   output logic [W-1:0] max_data,
   output logic         busy,
   output logic [7:0]   swap_cnt
);
   localparam int IW = $clog2(N);
   localparam logic [1:0] LOAD = 2'd0, SORT = 2'd1, EMIT = 2'd2;
   localparam logic [IW-1:0] TOP = IW'(N - 1), LAST = IW'(N - 2);
   logic [1:0]    state;
   logic [IW-1:0] wr_idx, rd_idx, idx, pass, nxt;
   logic          swapped, lt, end_pass;
   logic [W-1:0]  bank [N];
   assign nxt       = idx + 1'b1;
   assign lt        = bank[idx] < bank[nxt];
   assign end_pass  = idx == LAST - pass;
   assign in_ready  = state == LOAD;
   assign busy      = state == SORT;
   assign out_valid = state == EMIT;
   assign max_valid = out_valid;
   assign out_data  = out_valid ? bank[rd_idx] : '0;
   assign out_last  = out_valid && rd_idx == TOP;
   assign max_data  = out_valid ? bank[0] : '0;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= LOAD;
         wr_idx   <= '0;
         rd_idx   <= '0;
         idx      <= '0;
         pass     <= '0;
         swapped  <= 1'b0;
         swap_cnt <= '0;
         for (int i = 0; i < N; i++) bank[i] <= '0;
      end else if (flush) begin
         state  <= LOAD;
         wr_idx <= '0;
         rd_idx <= '0;
         idx    <= '0;
         pass   <= '0;
      end else if (state == LOAD) begin
         if (in_valid) begin
            bank[wr_idx] <= in_data;
            wr_idx       <= wr_idx == TOP ? '0 : wr_idx + 1'b1;
            if (wr_idx == TOP) begin
               state    <= SORT;
               idx      <= '0;
               pass     <= '0;
               swapped  <= 1'b0;
               swap_cnt <= '0;
            end
         end
      end else if (state == SORT) begin
         if (lt) begin
            bank[idx] <= bank[nxt];
            bank[nxt] <= bank[idx];
            swap_cnt  <= swap_cnt + 8'd1;
         end
         // a clean pass means the block is already ordered
         if (!end_pass) begin
            idx     <= nxt;
            swapped <= swapped || lt;
         end else if (!(swapped || lt) || pass == LAST) begin
            state  <= EMIT;
            rd_idx <= '0;
         end else begin
            pass    <= pass + 1'b1;
            idx     <= '0;
            swapped <= 1'b0;
         end
      end else if (state == EMIT) begin
         if (out_ready) begin
            rd_idx <= rd_idx == TOP ? '0 : rd_idx + 1'b1;
            if (rd_idx == TOP) state <= LOAD;
         end
      end else begin
         state <= LOAD;
      end
   end
endmodule

// File: tb/tb_sortmax_sched.sv
// tb_sortmax_sched: directed blocks with hand-computed sorted streams,
// sort latencies and swap counts for the N=8, W=8 scheduler.
module tb_sortmax_sched;
   logic       clk = 1'b0, rst = 1'b1, flush = 1'b0;
   logic       in_valid = 1'b0, out_ready = 1'b0;
   logic [7:0] in_data = '0;
   logic       in_ready, out_valid, out_last, max_valid, busy;
   logic [7:0] out_data, max_data, swap_cnt;
   int         passed = 0, total = 0;
   sortmax_sched #(.N(8), .W(8)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .max_valid(max_valid), .max_data(max_data),
      .busy(busy), .swap_cnt(swap_cnt)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   task automatic chk_idle(input string tag);
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      chk({tag, "_outs"}, {out_valid, out_last, max_valid, busy, out_data, max_data},
          64'd0);
   endtask
   task automatic load_blk(input logic [63:0] d, input bit rnd);
      for (int i = 0; i < 8; i++) begin
         repeat (rnd ? $urandom_range(0, 2) : 0) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(negedge clk);
         end
         in_valid = 1'b1;
         in_data  = d[63 - 8 * i -: 8];
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask
   task automatic sort_wait(input int exp_busy, input string tag);
      int cyc = 0, bad = 0;
      while (busy && cyc < 200) begin
         if (in_ready) bad++;
         cyc++;
         @(negedge clk);
      end
      chk({tag, "_busy_cycles"}, 64'(cyc), 64'(exp_busy));
      chk({tag, "_sort_ready"}, 64'(bad), 64'd0);
   endtask
   task automatic emit_blk(input logic [63:0] e, input int swaps, input bit rnd,
                           input string tag);
      logic [63:0] got = '0;
      logic [7:0]  prev = '0;
      logic        stall = 1'b0;
      int k = 0, guard = 0, bad_ready = 0, bad_stable = 0, bad_last = 0, bad_max = 0;
      while (k < 8 && guard < 300) begin
         guard++;
         if (in_ready) bad_ready++;
         if (!out_valid || !max_valid) bad_ready++;
         if (stall && out_data !== prev) bad_stable++;
         if (out_last !== (k == 7)) bad_last++;
         if (max_data !== e[63 -: 8]) bad_max++;
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (out_ready) begin
            got[63 - 8 * k -: 8] = out_data;
            k++;
         end
         stall = !out_ready;
         prev  = out_data;
         @(negedge clk);
      end
      out_ready = 1'b0;
      chk({tag, "_stream"}, got, e);
      chk({tag, "_emit_ready_valid"}, 64'(bad_ready), 64'd0);
      chk({tag, "_last"}, 64'(bad_last), 64'd0);
      chk({tag, "_max"}, 64'(bad_max), 64'd0);
      if (rnd) chk({tag, "_stall_stable"}, 64'(bad_stable), 64'd0);
      chk({tag, "_swap_cnt"}, 64'(swap_cnt), 64'(swaps));
      chk_idle({tag, "_after"});
   endtask
   initial begin
      int bad_ov;
      #1;
      chk_idle("reset");
      chk("reset_swap_cnt", 64'(swap_cnt), 64'd0);
      #11 rst = 1'b0;
      @(negedge clk);
      load_blk(64'h03_07_01_09_00_05_02_08, 1'b0);
      sort_wait(28, "mixed");
      emit_blk(64'h09_08_07_05_03_02_01_00, 15, 1'b0, "mixed");
      load_blk(64'h08_07_06_05_04_03_02_01, 1'b0);
      sort_wait(7, "desc");
      emit_blk(64'h08_07_06_05_04_03_02_01, 0, 1'b0, "desc");
      load_blk(64'h01_02_03_04_05_06_07_08, 1'b0);
      sort_wait(28, "asc");
      emit_blk(64'h08_07_06_05_04_03_02_01, 28, 1'b0, "asc");
      load_blk(64'h04_04_04_02_04_04_04_04, 1'b1);
      sort_wait(13, "equal");
      emit_blk(64'h04_04_04_04_04_04_04_02, 4, 1'b1, "equal");
      // two swaps land before the flush takes effect on the third SORT cycle
      load_blk(64'h01_02_03_04_05_06_07_08, 1'b0);
      @(negedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      chk("flush_busy", 64'(busy), 64'd0);
      chk("flush_swap_cnt", 64'(swap_cnt), 64'd2);
      bad_ov = 0;
      repeat (5) begin
         if (out_valid) bad_ov++;
         @(negedge clk);
      end
      chk("flush_no_out_valid", 64'(bad_ov), 64'd0);
      load_blk(64'h03_07_01_09_00_05_02_08, 1'b0);
      sort_wait(28, "postflush");
      emit_blk(64'h09_08_07_05_03_02_01_00, 15, 1'b0, "postflush");
      load_blk(64'h08_07_06_05_04_03_02_01, 1'b0);
      sort_wait(7, "prerst");
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      out_ready = 1'b0;
      chk("prerst_word3", {56'd0, out_valid, out_data}, 64'h1_05);
      #2 rst = 1'b1;
      #1;
      chk_idle("midrst");
      chk("midrst_swap_cnt", 64'(swap_cnt), 64'd0);
      #1 rst = 1'b0;
      @(negedge clk);
      load_blk(64'h03_07_01_09_00_05_02_08, 1'b0);
      sort_wait(28, "postrst");
      emit_blk(64'h09_08_07_05_03_02_01_00, 15, 1'b0, "postrst");
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
